// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: opcodes, control-bundle layout, interrupt FSM
// encoding and instruction field positions.
package cpu_pkg;

  localparam int unsigned OpcodeW = 3;

  localparam logic [OpcodeW-1:0] OpAlu    = 3'b000;
  localparam logic [OpcodeW-1:0] OpAluImm = 3'b001;
  localparam logic [OpcodeW-1:0] OpLoad   = 3'b010;
  localparam logic [OpcodeW-1:0] OpStore  = 3'b011;
  localparam logic [OpcodeW-1:0] OpBranch = 3'b100;
  localparam logic [OpcodeW-1:0] OpJump   = 3'b101;
  localparam logic [OpcodeW-1:0] OpSys    = 3'b110;
  localparam logic [OpcodeW-1:0] OpNop    = 3'b111;

  // Control bundle layout as produced by the control unit.
  localparam int unsigned CtrlAluOpLsb  = 0;
  localparam int unsigned CtrlAluOpW    = 4;
  localparam int unsigned CtrlRegWrite  = 4;
  localparam int unsigned CtrlMemRead   = 5;
  localparam int unsigned CtrlMemWrite  = 6;
  localparam int unsigned CtrlBranch    = 7;
  localparam int unsigned CtrlJump      = 8;
  localparam int unsigned CtrlAluSrc    = 9;
  localparam int unsigned CtrlMemToReg  = 10;
  localparam int unsigned CtrlImmLsb    = 11;
  localparam int unsigned CtrlImmW      = 13;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrain  = 2'd1,
    StPush   = 2'd2,
    StVector = 2'd3
  } int_state_e;

  // rd sits directly below the opcode, rs directly below rd.
  function automatic int unsigned rd_lsb(input int unsigned instr_w, input int unsigned aw);
    return instr_w - OpcodeW - aw;
  endfunction

  function automatic int unsigned rs_lsb(input int unsigned instr_w, input int unsigned aw);
    return instr_w - OpcodeW - 2 * aw;
  endfunction

endpackage

// File: rtl/register_file_bypass.sv
// Register file with two combinational read ports and write-through bypass.
// A disabled read port returns zero.
module register_file_bypass #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ren1,
  input  logic [AW-1:0]     i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_ren2,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (i_we) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_ren1) begin
      o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : regs_q[i_raddr1];
    end
    if (i_ren2) begin
      o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : regs_q[i_raddr2];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: operand read, load-use interlock, branch flush, interrupt
// injection (drain / push PC / vector) and the registered ID/EX boundary.
module decode_stage_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned CTRL_W   = 24,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_instr_valid,
  input  logic [CTRL_W-1:0]  i_ctrl,
  input  logic               i_read1,
  input  logic               i_read2,
  input  logic               i_interrupt,
  input  logic               i_flush,
  input  logic               i_ex_mem_read,
  input  logic [AW-1:0]      i_ex_rd,
  input  logic               i_write_back,
  input  logic [AW-1:0]      i_write_addr,
  input  logic [DATA_W-1:0]  i_write_data,
  output logic               o_stall,
  output logic               o_int_vector,
  output logic               o_valid,
  output logic [CTRL_W-1:0]  o_ctrl,
  output logic               o_push_pc,
  output logic [DATA_W-1:0]  o_data1,
  output logic [DATA_W-1:0]  o_data2,
  output logic [AW-1:0]      o_rd,
  output logic [AW-1:0]      o_rs
);

  localparam int unsigned RdLsb = rd_lsb(INSTR_W, AW);
  localparam int unsigned RsLsb = rs_lsb(INSTR_W, AW);

  logic [AW-1:0]     rd, rs;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              hz;
  logic              unused_instr;

  int_state_e state_q, state_d;
  logic       pending_q, pending_d;
  logic       int_vec_q, int_vec_d;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [AW-1:0]     rd_q, rd_d, rs_q, rs_d;

  assign rd = i_instr[RdLsb +: AW];
  assign rs = i_instr[RsLsb +: AW];
  // Opcode and immediate bits are consumed by the control unit, not here.
  assign unused_instr = ^{i_instr[INSTR_W-1 -: OpcodeW], i_instr[RsLsb-1:0]};

  register_file_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (i_write_back),
    .i_waddr   (i_write_addr),
    .i_wdata   (i_write_data),
    .i_ren1    (i_read1),
    .i_raddr1  (rd),
    .o_rdata1  (rdata1),
    .i_ren2    (i_read2),
    .i_raddr2  (rs),
    .o_rdata2  (rdata2)
  );

  assign hz = i_instr_valid & i_ex_mem_read &
              ((i_read1 & (i_ex_rd == rd)) | (i_read2 & (i_ex_rd == rs)));

  // Flush cannot coincide with PUSH/VECTOR, so those stall unconditionally.
  assign o_stall = (state_q == StPush) | (state_q == StVector) |
                   (~i_flush & (hz | (state_q == StDrain)));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | i_interrupt;
    int_vec_d = (state_q == StVector);
    unique case (state_q)
      StIdle: begin
        if (pending_q && !hz && !i_flush) state_d = StDrain;
      end
      StDrain: begin
        // A taken branch kills the drained op; retry once the branch resolves.
        if (i_flush)  state_d = StIdle;
        else if (!hz) state_d = StPush;
      end
      StPush: begin
        state_d   = StVector;
        pending_d = 1'b0;
      end
      StVector: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = '0;
    push_d  = 1'b0;
    data1_d = '0;
    data2_d = '0;
    rd_d    = '0;
    rs_d    = '0;
    if (state_q == StPush) begin
      valid_d = 1'b1;
      push_d  = 1'b1;
    end else if ((state_q == StVector) || i_flush || hz) begin
      valid_d = 1'b0;
    end else begin
      valid_d = i_instr_valid;
      ctrl_d  = i_ctrl;
      data1_d = rdata1;
      data2_d = rdata2;
      rd_d    = rd;
      rs_d    = rs;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      int_vec_q <= 1'b0;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      push_q    <= 1'b0;
      data1_q   <= '0;
      data2_q   <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      int_vec_q <= int_vec_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      push_q    <= push_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
    end
  end

  assign o_int_vector = int_vec_q;
  assign o_valid      = valid_q;
  assign o_ctrl       = ctrl_q;
  assign o_push_pc    = push_q;
  assign o_data1      = data1_q;
  assign o_data2      = data2_q;
  assign o_rd         = rd_q;
  assign o_rs         = rs_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: vector table for single-cycle decode
// behaviour plus hand-written interrupt and reset sequences.
module tb_decode_stage_pipe;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [15:0] i_instr;
  logic        i_instr_valid;
  logic [23:0] i_ctrl;
  logic        i_read1, i_read2, i_interrupt, i_flush, i_ex_mem_read;
  logic [2:0]  i_ex_rd;
  logic        i_write_back;
  logic [2:0]  i_write_addr;
  logic [15:0] i_write_data;
  logic        o_stall, o_int_vector, o_valid, o_push_pc;
  logic [23:0] o_ctrl;
  logic [15:0] o_data1, o_data2;
  logic [2:0]  o_rd, o_rs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  decode_stage_pipe dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_instr       (i_instr),
    .i_instr_valid (i_instr_valid),
    .i_ctrl        (i_ctrl),
    .i_read1       (i_read1),
    .i_read2       (i_read2),
    .i_interrupt   (i_interrupt),
    .i_flush       (i_flush),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rd       (i_ex_rd),
    .i_write_back  (i_write_back),
    .i_write_addr  (i_write_addr),
    .i_write_data  (i_write_data),
    .o_stall       (o_stall),
    .o_int_vector  (o_int_vector),
    .o_valid       (o_valid),
    .o_ctrl        (o_ctrl),
    .o_push_pc     (o_push_pc),
    .o_data1       (o_data1),
    .o_data2       (o_data2),
    .o_rd          (o_rd),
    .o_rs          (o_rs)
  );

  typedef struct {
    logic [15:0] instr;
    logic        ivalid;
    logic [23:0] ctrl;
    logic        r1, r2, exmr;
    logic [2:0]  exrd;
    logic        flush, wb;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        e_stall, e_valid;
    logic [23:0] e_ctrl;
    logic [15:0] e_d1, e_d2;
    logic [2:0]  e_rd, e_rs;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [15:0] mk(input logic [2:0] rd, input logic [2:0] rs);
    return {3'b000, rd, rs, 7'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic defaults();
    i_instr       = mk(3'd3, 3'd0);
    i_instr_valid = 1'b1;
    i_ctrl        = 24'h0A0A0A;
    i_read1       = 1'b1;
    i_read2       = 1'b0;
    i_interrupt   = 1'b0;
    i_flush       = 1'b0;
    i_ex_mem_read = 1'b0;
    i_ex_rd       = 3'd0;
    i_write_back  = 1'b0;
    i_write_addr  = 3'd0;
    i_write_data  = 16'h0;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, 32'(o_stall), 32'd0);
    chk({tag, " int_vector"}, 32'(o_int_vector), 32'd0);
    chk({tag, " valid"}, 32'(o_valid), 32'd0);
    chk({tag, " ctrl"}, 32'(o_ctrl), 32'd0);
    chk({tag, " push_pc"}, 32'(o_push_pc), 32'd0);
    chk({tag, " data1"}, 32'(o_data1), 32'd0);
    chk({tag, " data2"}, 32'(o_data2), 32'd0);
    chk({tag, " rd"}, 32'(o_rd), 32'd0);
    chk({tag, " rs"}, 32'(o_rs), 32'd0);
  endtask

  // One interrupt-sequence cycle: drive, check stall, clock, check ID/EX.
  task automatic seq_step(input string tag, input int idx, input logic intr, input logic fl,
                          input logic e_stall, input logic e_valid, input logic e_push,
                          input logic e_iv);
    i_interrupt = intr;
    i_flush     = fl;
    #2;
    chk($sformatf("%s[%0d] stall", tag, idx), 32'(o_stall), 32'(e_stall));
    cycle();
    chk($sformatf("%s[%0d] valid", tag, idx), 32'(o_valid), 32'(e_valid));
    chk($sformatf("%s[%0d] push_pc", tag, idx), 32'(o_push_pc), 32'(e_push));
    chk($sformatf("%s[%0d] int_vector", tag, idx), 32'(o_int_vector), 32'(e_iv));
    chk($sformatf("%s[%0d] ctrl", tag, idx), 32'(o_ctrl),
        (e_valid && !e_push) ? 32'h0A0A0A : 32'h0);
  endtask

  initial begin
    logic [7:0] s_int, s_stall, s_valid, s_push, s_iv, s_fl;
    int iv_pulses;

    vecs[0]  = '{mk(3'd3, 3'd0), 1'b1, 24'hABCDE1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3,
                 16'h1234, 1'b0, 1'b1, 24'hABCDE1, 16'h1234, 16'h0000, 3'd3, 3'd0};
    vecs[1]  = '{mk(3'd3, 3'd5), 1'b1, 24'h000111, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5,
                 16'hBEEF, 1'b0, 1'b1, 24'h000111, 16'h1234, 16'hBEEF, 3'd3, 3'd5};
    vecs[2]  = '{mk(3'd5, 3'd3), 1'b1, 24'h222222, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0,
                 16'h0000, 1'b0, 1'b1, 24'h222222, 16'hBEEF, 16'h0000, 3'd5, 3'd3};
    vecs[3]  = '{mk(3'd4, 3'd2), 1'b1, 24'h333333, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0,
                 16'h0000, 1'b1, 1'b0, 24'h0, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[4]  = '{mk(3'd4, 3'd2), 1'b1, 24'h333333, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 3'd2,
                 16'h0042, 1'b0, 1'b1, 24'h333333, 16'h0000, 16'h0042, 3'd4, 3'd2};
    vecs[5]  = '{mk(3'd4, 3'd2), 1'b1, 24'h333333, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0,
                 16'h0000, 1'b0, 1'b0, 24'h0, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[6]  = '{mk(3'd3, 3'd5), 1'b1, 24'h444444, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0,
                 16'h0000, 1'b0, 1'b1, 24'h444444, 16'h0000, 16'hBEEF, 3'd3, 3'd5};
    vecs[7]  = '{mk(3'd3, 3'd0), 1'b0, 24'h555555, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0,
                 16'h0000, 1'b0, 1'b0, 24'h555555, 16'h1234, 16'h0000, 3'd3, 3'd0};
    vecs[8]  = '{mk(3'd7, 3'd0), 1'b1, 24'h666666, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0,
                 16'h0000, 1'b1, 1'b0, 24'h0, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[9]  = '{mk(3'd7, 3'd0), 1'b1, 24'h666666, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 3'd7,
                 16'h7777, 1'b0, 1'b1, 24'h666666, 16'h7777, 16'h0000, 3'd7, 3'd0};
    vecs[10] = '{mk(3'd1, 3'd1), 1'b1, 24'h777777, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0,
                 16'h0000, 1'b0, 1'b0, 24'h0, 16'h0000, 16'h0000, 3'd0, 3'd0};

    // Reset state.
    i_reset_n = 1'b0;
    defaults();
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Single-cycle decode vectors.
    for (int v = 0; v < 11; v++) begin
      i_instr       = vecs[v].instr;
      i_instr_valid = vecs[v].ivalid;
      i_ctrl        = vecs[v].ctrl;
      i_read1       = vecs[v].r1;
      i_read2       = vecs[v].r2;
      i_ex_mem_read = vecs[v].exmr;
      i_ex_rd       = vecs[v].exrd;
      i_flush       = vecs[v].flush;
      i_write_back  = vecs[v].wb;
      i_write_addr  = vecs[v].waddr;
      i_write_data  = vecs[v].wdata;
      #2;
      chk($sformatf("vec%0d stall", v), 32'(o_stall), 32'(vecs[v].e_stall));
      cycle();
      chk($sformatf("vec%0d valid", v), 32'(o_valid), 32'(vecs[v].e_valid));
      chk($sformatf("vec%0d ctrl", v), 32'(o_ctrl), 32'(vecs[v].e_ctrl));
      chk($sformatf("vec%0d data1", v), 32'(o_data1), 32'(vecs[v].e_d1));
      chk($sformatf("vec%0d data2", v), 32'(o_data2), 32'(vecs[v].e_d2));
      chk($sformatf("vec%0d rd", v), 32'(o_rd), 32'(vecs[v].e_rd));
      chk($sformatf("vec%0d rs", v), 32'(o_rs), 32'(vecs[v].e_rs));
      chk($sformatf("vec%0d push_pc", v), 32'(o_push_pc), 32'd0);
      chk($sformatf("vec%0d int_vector", v), 32'(o_int_vector), 32'd0);
    end

    // Interrupt pulse in IDLE: latch, DRAIN, PUSH, VECTOR, vector pulse.
    defaults();
    s_int   = 8'b0000_0001;
    s_stall = 8'b0001_1100;
    s_valid = 8'b0010_1111;
    s_push  = 8'b0000_1000;
    s_iv    = 8'b0001_0000;
    iv_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      seq_step("irq", c, s_int[c], 1'b0, s_stall[c], s_valid[c], s_push[c], s_iv[c]);
      if (o_int_vector) iv_pulses++;
    end
    chk("irq vector pulse count", 32'(iv_pulses), 32'd1);

    // Flush during DRAIN: bubble, back to IDLE, pending re-arbitrates.
    s_int   = 8'b0000_0001;
    s_fl    = 8'b0000_0100;
    s_stall = 8'b0111_0000;
    s_valid = 8'b1011_1011;
    s_push  = 8'b0010_0000;
    s_iv    = 8'b0100_0000;
    for (int c = 0; c < 8; c++) begin
      seq_step("drainflush", c, s_int[c], s_fl[c], s_stall[c], s_valid[c], s_push[c], s_iv[c]);
    end

    // Reset asserted while in PUSH.
    s_int   = 8'b0000_0001;
    s_stall = 8'b0000_0100;
    s_valid = 8'b0000_0111;
    s_push  = 8'b0000_0000;
    s_iv    = 8'b0000_0000;
    for (int c = 0; c < 3; c++) begin
      seq_step("rstpush", c, s_int[c], 1'b0, s_stall[c], s_valid[c], s_push[c], s_iv[c]);
    end
    #2;
    chk("rstpush in PUSH stall", 32'(o_stall), 32'd1);
    i_reset_n = 1'b0;
    #1;
    chk_all_zero("rstpush async");
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    i_instr = mk(3'd3, 3'd5);
    i_read2 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("post-reset[%0d] stall", c), 32'(o_stall), 32'd0);
      cycle();
      chk($sformatf("post-reset[%0d] int_vector", c), 32'(o_int_vector), 32'd0);
      chk($sformatf("post-reset[%0d] push_pc", c), 32'(o_push_pc), 32'd0);
      chk($sformatf("post-reset[%0d] data1", c), 32'(o_data1), 32'd0);
      chk($sformatf("post-reset[%0d] data2", c), 32'(o_data2), 32'd0);
      chk($sformatf("post-reset[%0d] valid", c), 32'(o_valid), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
